soc_system_hps_fifo_wr_port: RTL
================================

# soc_system_hps_fifo_wr_port

Avalon-MM slave that lets the HPS push 32-bit words into the FPGA-side FIFO write port. It is the producer end of the HPS FIFO path, the counterpart of the status port that reports FIFO fill state. Writes land in a small circular holding buffer, which drains into the FIFO only while the FIFO's `wrfull` is low. Overflow is counted and flagged instead of stalling the bus: there is no waitrequest.

## Interface
- `DEPTH`, 4: holding-buffer entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: occupancy counter width (derived; not overridden).

- `clk`  in  1  single clock for bus and FIFO write side.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  active-low write.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `fifo_wrfull`  in  1  FIFO full, same clock domain.
- `fifo_wrreq`  out  1  FIFO write request (combinational).
- `fifo_data`  out  32  FIFO write data (buffer head).

## Operation
- **Register map.**
  - addr 0 DATA: a write pushes `writedata`; a read returns 0.
  - addr 1 STATUS, read-only:
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [3] `fifo_wrfull`
    - [4] enable
    - [15:8] occupancy, zero-extended
  - addr 2 CTRL:
    - [0] enable, R/W.
    - [1] is write-1-to-clear for overflow and reads 0.
  - addr 3 DROPCNT: 16-bit dropped-word count; any write clears it.
- **Push.** Push strobe = `chipselect & ~write_n & address==0`.
  - If the buffer is not full, the word is written at the tail; tail and occupancy advance.
  - If the buffer is full, the word is dropped; overflow sets; DROPCNT increments and saturates at 0xFFFF.
- **Drain.**
  - `fifo_wrreq = enable & ~empty & ~fifo_wrfull`.
  - `fifo_data` = head entry at all times (don't-care when empty).
  - A pop occurs on every edge where `fifo_wrreq`=1; head advances and occupancy decrements.
- **Simultaneous push and pop.**
  - Non-full: occupancy unchanged, both pointers advance.
  - Full: the pop frees a slot in the same edge, so the push is accepted and nothing is dropped.
- **Clear vs. event in the same cycle.**
  - CTRL[1] write together with an overflowing push: overflow ends at 1 (the event wins).
  - DROPCNT clear together with a drop: DROPCNT ends at 1.
- **Pointers.** Wrap modulo DEPTH; occupancy ranges 0..DEPTH.
- **Disable.** Clearing enable stops draining immediately; buffered words are retained.
- **Reset values.**
  - readdata=0, pointers=0, occupancy=0, enable=0, overflow=0, DROPCNT=0.
  - Therefore `fifo_wrreq`=0 out of reset.
  - Buffer RAM contents are not reset.

## Timing
- `readdata` is registered and updated every cycle from `address`: read latency 1.
- Register and status writes take effect at the strobe edge and are visible to a read issued on the next cycle.
- Earliest drain is one cycle after the push edge. Sustained throughput is 1 word/cycle while `fifo_wrfull`=0.
- `fifo_wrfull` is used unregistered.
  - The FIFO's registered `wrfull` guarantees a request issued while it is low is accepted.
  - No words are lost at the FIFO boundary.
- Reset asserted mid-drain: at the next edge `fifo_wrreq` drops to 0 and buffered words are discarded.

## Structure
- **Shared package `soc_system_hps_fifo_pkg`:**
  - address constants `ADDR_DATA`/`ADDR_STATUS`/`ADDR_CTRL`/`ADDR_DROPCNT`;
  - STATUS bit indices;
  - CTRL bit indices;
  - DROPCNT width (16).
- **Sub-module `soc_system_hps_fifo_wr_buf`:**
  - contains DEPTH×32 circular buffer, head/tail pointers and occupancy;
  - ports: push, pop, din, dout, empty, full, count.
- **Top level:** Avalon decode, CTRL/overflow/DROPCNT registers, readdata mux and drain gating.

## Test plan
- **Reset, then push, no enable:** reset, write CTRL=0, push 0xA5A5_0001.
  - `fifo_wrreq` stays 0.
  - STATUS reads 0x0000_0100 (occupancy 1, not empty).
- **Drain with backpressure:**
  - Stimulus: push 0x11, 0x22, 0x33, then set enable; hold `fifo_wrfull`=1 for 3 cycles, then release.
  - Required: no requests while `fifo_wrfull`=1; afterwards three consecutive `fifo_wrreq` cycles carrying 0x11, 0x22, 0x33 in order; STATUS[0]=1 afterwards.
- **Overflow:**
  - Stimulus: enable=0, push DEPTH+2 = 6 words.
  - Required: STATUS[1]=1, STATUS[2]=1, DROPCNT=2, buffer holds the first 4 words.
  - Then write CTRL=0x3: overflow reads 0.
- **Full with simultaneous push and pop:**
  - Stimulus: fill 4 words, set enable, and issue a push on the first pop cycle.
  - Required: no drop (DROPCNT=0); 5 words emitted in push order.
- **Pointer wrap:** 10 push/pop pairs with enable=1 and `fifo_wrfull`=0.
  - Outputs match push order.
  - Occupancy never exceeds 1.
- **Reset mid-drain:**
  - Stimulus: assert `reset_n`=0 for 1 cycle while 3 words are pending.
  - Required: `fifo_wrreq`=0 from the next edge; STATUS=0x0000_0001; DROPCNT=0.

Source files
------------

// File: rtl/soc_system_hps_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_hps_fifo_pkg
//  Description : Shared constants for the HPS FIFO write/status ports:
//                register addresses, STATUS/CTRL bit indices, DROPCNT width.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_hps_fifo_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_DROPCNT = 2'd3;

    // STATUS bit positions
    localparam int STS_EMPTY   = 0;
    localparam int STS_FULL    = 1;
    localparam int STS_OVF     = 2;
    localparam int STS_WRFULL  = 3;
    localparam int STS_EN      = 4;
    localparam int STS_OCC_LSB = 8;
    localparam int STS_OCC_W   = 8;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_OVF_CLR = 1;

    // Dropped-word counter width
    localparam int DROPCNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/soc_system_hps_fifo_wr_buf.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_hps_fifo_wr_buf
//  Description : DEPTH x 32 circular holding buffer with head/tail pointers
//                and occupancy. A push while full is accepted only when a pop
//                frees a slot on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_hps_fifo_wr_buf
    import soc_system_hps_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_wr_en;
    logic             w_rd_en;

    // Qualify push/pop against occupancy and compute next pointers/count
    always_comb begin
        w_rd_en = pop & (count_q != '0);
        w_wr_en = push & ((count_q != CNT_W'(DEPTH)) | w_rd_en);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_rd_en) begin
            head_d = head_q + PTR_W'(1);
        end
        if (w_wr_en) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({w_wr_en, w_rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout  = mem_q[head_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/soc_system_hps_fifo_wr_port.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_hps_fifo_wr_port
//  Description : Avalon-MM slave feeding 32-bit words from the HPS into the
//                FPGA FIFO write port through a small holding buffer. No
//                waitrequest: overflow is counted and flagged, never stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_hps_fifo_wr_port
    import soc_system_hps_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        fifo_wrfull,
    output logic        fifo_wrreq,
    output logic [31:0] fifo_data
);

    logic                 enable_q,   enable_d;
    logic                 overflow_q, overflow_d;
    logic [DROPCNT_W-1:0] dropcnt_q,  dropcnt_d;
    logic [31:0]          readdata_q, readdata_d;

    logic                 w_wr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_ctrl_wr;
    logic                 w_dropcnt_wr;
    logic                 w_buf_empty;
    logic                 w_buf_full;
    logic [CNT_W-1:0]     w_buf_count;
    logic [31:0]          w_status;

    soc_system_hps_fifo_wr_buf #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (writedata),
        .dout    (fifo_data),
        .empty   (w_buf_empty),
        .full    (w_buf_full),
        .count   (w_buf_count)
    );

    // Bus decode and drain gating; a full buffer drops only if no pop frees a slot
    always_comb begin
        w_wr         = chipselect & ~write_n;
        w_push       = w_wr & (address == ADDR_DATA);
        w_ctrl_wr    = w_wr & (address == ADDR_CTRL);
        w_dropcnt_wr = w_wr & (address == ADDR_DROPCNT);
        w_pop        = enable_q & ~w_buf_empty & ~fifo_wrfull;
        w_drop       = w_push & w_buf_full & ~w_pop;
    end

    assign fifo_wrreq = w_pop;

    // Control registers; clears are applied first so a same-cycle event wins
    always_comb begin
        enable_d   = enable_q;
        overflow_d = overflow_q;
        dropcnt_d  = dropcnt_q;
        if (w_ctrl_wr) begin
            enable_d = writedata[CTRL_EN];
            if (writedata[CTRL_OVF_CLR]) begin
                overflow_d = 1'b0;
            end
        end
        if (w_dropcnt_wr) begin
            dropcnt_d = '0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
            if (dropcnt_d != '1) begin
                dropcnt_d = dropcnt_d + DROPCNT_W'(1);
            end
        end
    end

    // Read mux; sampled every cycle to give a fixed one-cycle read latency
    always_comb begin
        w_status                                = '0;
        w_status[STS_EMPTY]                     = w_buf_empty;
        w_status[STS_FULL]                      = w_buf_full;
        w_status[STS_OVF]                       = overflow_q;
        w_status[STS_WRFULL]                    = fifo_wrfull;
        w_status[STS_EN]                        = enable_q;
        w_status[STS_OCC_LSB +: STS_OCC_W]      = STS_OCC_W'(w_buf_count);
        readdata_d                              = '0;
        case (address)
            ADDR_STATUS:  readdata_d = w_status;
            ADDR_CTRL:    readdata_d[CTRL_EN] = enable_q;
            ADDR_DROPCNT: readdata_d[DROPCNT_W-1:0] = dropcnt_q;
            default:      readdata_d = '0;
        endcase
    end

    // Register state update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            dropcnt_q  <= '0;
            readdata_q <= '0;
        end else begin
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            dropcnt_q  <= dropcnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
`default_nettype wire
